// File: rtl/seq_gen_pkg.sv
// Shared constants and state encoding for the serial sequence generator.
package seq_gen_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_LEN_W = 4;
    localparam int DEF_REP_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        SEND = ST_SEND,
        GAP  = ST_GAP,
        DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/seq_gen_if.sv
// Request/stream bundle between a pattern source and the seq_gen transmitter.
interface seq_gen_if
    import seq_gen_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LEN_W = DEF_LEN_W,
    parameter int REP_W = DEF_REP_W
) ();

    logic             start;
    logic [WIDTH-1:0] pattern;
    logic [LEN_W-1:0] len;
    logic [REP_W-1:0] reps;
    logic             a_out;
    logic             valid;
    logic             busy;
    logic             done;

    modport master (
        output start, pattern, len, reps,
        input  a_out, valid, busy, done
    );

    modport slave (
        input  start, pattern, len, reps,
        output a_out, valid, busy, done
    );

endinterface

// File: rtl/seq_gen_piso_shift.sv
// Parallel-load pattern register with an indexed single-bit read port.
module piso_shift
    import seq_gen_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LEN_W = DEF_LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic [LEN_W-1:0] idx,
    output logic             bit_out
);

    logic [WIDTH-1:0] pat_q;
    logic [WIDTH-1:0] sel;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_q <= '0;
        end else if (load) begin
            pat_q <= din;
        end
    end

    // One-hot mask keeps every pattern bit observable and tolerates wide idx.
    assign sel     = {{(WIDTH-1){1'b0}}, 1'b1} << idx;
    assign bit_out = |(pat_q & sel);

endmodule

// File: rtl/seq_gen.sv
// Serial transmitter: shifts a captured pattern out MSB-first, with repeats
// separated by a one-cycle gap and a one-cycle done pulse at the end.
module seq_gen
    import seq_gen_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LEN_W = DEF_LEN_W,
    parameter int REP_W = DEF_REP_W
) (
    input  logic      clk,
    input  logic      rst,
    seq_gen_if.slave  bus
);

    state_t           state, state_n;
    logic [LEN_W-1:0] idx, idx_n;
    logic [LEN_W-1:0] len_q, len_n;
    logic [REP_W-1:0] rep_cnt, rep_n;
    logic             load;
    logic             len_ok;
    logic             cur_bit;

    assign len_ok = (bus.len != '0) && (bus.len <= LEN_W'(WIDTH));

    piso_shift #(
        .WIDTH (WIDTH),
        .LEN_W (LEN_W)
    ) u_piso (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .din     (bus.pattern),
        .idx     (idx),
        .bit_out (cur_bit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            idx     <= '0;
            len_q   <= '0;
            rep_cnt <= '0;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            len_q   <= len_n;
            rep_cnt <= rep_n;
        end
    end

    // Next-state and counter updates; idx floors at 0 and rep_cnt at 1.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        len_n   = len_q;
        rep_n   = rep_cnt;
        load    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start && len_ok) begin
                    state_n = SEND;
                    load    = 1'b1;
                    len_n   = bus.len;
                    idx_n   = bus.len - LEN_W'(1);
                    rep_n   = (bus.reps == '0) ? REP_W'(1) : bus.reps;
                end
            end
            SEND: begin
                if (idx != '0) begin
                    idx_n = idx - LEN_W'(1);
                end else if (rep_cnt > REP_W'(1)) begin
                    rep_n   = rep_cnt - REP_W'(1);
                    state_n = GAP;
                end else begin
                    state_n = DONE;
                end
            end
            GAP: begin
                idx_n   = len_q - LEN_W'(1);
                state_n = SEND;
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Outputs decode only registered state, so reset clears them at once.
    always_comb begin
        bus.valid = (state == SEND);
        bus.a_out = (state == SEND) && cur_bit;
        bus.busy  = (state != IDLE);
        bus.done  = (state == DONE);
    end

endmodule

// File: tb/tb_seq_gen.sv
// Directed self-checking bench for seq_gen; outputs sampled on the falling edge.
module tb_seq_gen;

    logic clk;
    logic rst;
    int   total;
    int   passed;

    seq_gen_if bus ();

    seq_gen dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Request is presented for one rising edge; returns in the first SEND cycle.
    task automatic drive_start(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r);
        @(negedge clk);
        bus.pattern = p;
        bus.len     = l;
        bus.reps    = r;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start   = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] got;
        rst         = 1'b0;
        bus.start   = 1'b1;
        bus.pattern = 8'h0B;
        bus.len     = 4'd4;
        bus.reps    = 4'd1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            got = {bus.a_out, bus.valid, bus.busy, bus.done};
            total++;
            if (got !== 4'b0000)
                $display("[TB] FAIL reset_hold cycle %0d: got %b want %b (a_out,valid,busy,done)", i, got, 4'b0000);
            else
                passed++;
        end
        bus.start = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        got = {bus.a_out, bus.valid, bus.busy, bus.done};
        total++;
        if (got !== 4'b0000)
            $display("[TB] FAIL reset_release: got %b want %b (a_out,valid,busy,done)", got, 4'b0000);
        else
            passed++;
    endtask

    task automatic test_single(input logic [3:0] r);
        logic [3:0] exp [6];
        logic [3:0] got;
        exp = '{4'b1110, 4'b0110, 4'b1110, 4'b1110, 4'b0011, 4'b0000};
        drive_start(8'h0B, 4'd4, r);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            got = {bus.a_out, bus.valid, bus.busy, bus.done};
            total++;
            if (got !== exp[i])
                $display("[TB] FAIL single_reps%0d cycle %0d: got %b want %b (a_out,valid,busy,done)", r, i, got, exp[i]);
            else
                passed++;
        end
    endtask

    task automatic test_repeat();
        logic [3:0] exp [10];
        logic [3:0] got;
        exp = '{4'b1110, 4'b0110, 4'b0010, 4'b1110, 4'b0110, 4'b0010,
                4'b1110, 4'b0110, 4'b0011, 4'b0000};
        drive_start(8'h02, 4'd2, 4'd3);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            got = {bus.a_out, bus.valid, bus.busy, bus.done};
            total++;
            if (got !== exp[i])
                $display("[TB] FAIL repeat cycle %0d: got %b want %b (a_out,valid,busy,done)", i, got, exp[i]);
            else
                passed++;
        end
    endtask

    task automatic test_illegal();
        logic [3:0] exp [10];
        logic [3:0] got;
        logic [3:0] bad [2];
        bad = '{4'd0, 4'd9};
        for (int b = 0; b < 2; b++) begin
            drive_start(8'hFF, bad[b], 4'd1);
            for (int i = 0; i < 2; i++) begin
                if (i > 0) @(negedge clk);
                got = {bus.a_out, bus.valid, bus.busy, bus.done};
                total++;
                if (got !== 4'b0000)
                    $display("[TB] FAIL illegal_len%0d cycle %0d: got %b want %b (a_out,valid,busy,done)", bad[b], i, got, 4'b0000);
                else
                    passed++;
            end
        end
        exp = '{4'b1110, 4'b0110, 4'b1110, 4'b0110, 4'b0110, 4'b1110,
                4'b0110, 4'b1110, 4'b0011, 4'b0000};
        drive_start(8'hA5, 4'd8, 4'd1);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            got = {bus.a_out, bus.valid, bus.busy, bus.done};
            total++;
            if (got !== exp[i])
                $display("[TB] FAIL full_len8 cycle %0d: got %b want %b (a_out,valid,busy,done)", i, got, exp[i]);
            else
                passed++;
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp [10];
        logic [3:0] got;
        exp = '{4'b1110, 4'b0110, 4'b1110, 4'b1110, 4'b0011, 4'b0000,
                4'b1110, 4'b0110, 4'b0011, 4'b0000};
        drive_start(8'h0B, 4'd4, 4'd1);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            bus.start = 1'b0;
            if (i == 1) begin
                bus.start   = 1'b1;
                bus.pattern = 8'hF0;
                bus.len     = 4'd8;
                bus.reps    = 4'd2;
            end else if (i == 4) begin
                bus.start   = 1'b1;
                bus.pattern = 8'h00;
                bus.len     = 4'd3;
                bus.reps    = 4'd1;
            end else if (i == 5) begin
                bus.start   = 1'b1;
                bus.pattern = 8'h02;
                bus.len     = 4'd2;
                bus.reps    = 4'd1;
            end
            got = {bus.a_out, bus.valid, bus.busy, bus.done};
            total++;
            if (got !== exp[i])
                $display("[TB] FAIL collision cycle %0d: got %b want %b (a_out,valid,busy,done)", i, got, exp[i]);
            else
                passed++;
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [3:0] exp [3];
        logic [3:0] post [4];
        logic [3:0] got;
        exp  = '{4'b1110, 4'b0110, 4'b1110};
        post = '{4'b1110, 4'b0110, 4'b0011, 4'b0000};
        drive_start(8'h0B, 4'd4, 4'd2);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            got = {bus.a_out, bus.valid, bus.busy, bus.done};
            total++;
            if (got !== exp[i])
                $display("[TB] FAIL pre_reset cycle %0d: got %b want %b (a_out,valid,busy,done)", i, got, exp[i]);
            else
                passed++;
        end
        rst = 1'b0;
        #1;
        got = {bus.a_out, bus.valid, bus.busy, bus.done};
        total++;
        if (got !== 4'b0000)
            $display("[TB] FAIL async_reset: got %b want %b (a_out,valid,busy,done)", got, 4'b0000);
        else
            passed++;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            got = {bus.a_out, bus.valid, bus.busy, bus.done};
            total++;
            if (got !== 4'b0000)
                $display("[TB] FAIL reset_no_done cycle %0d: got %b want %b (a_out,valid,busy,done)", i, got, 4'b0000);
            else
                passed++;
        end
        rst = 1'b1;
        @(negedge clk);
        got = {bus.a_out, bus.valid, bus.busy, bus.done};
        total++;
        if (got !== 4'b0000)
            $display("[TB] FAIL after_release: got %b want %b (a_out,valid,busy,done)", got, 4'b0000);
        else
            passed++;
        drive_start(8'h02, 4'd2, 4'd1);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            got = {bus.a_out, bus.valid, bus.busy, bus.done};
            total++;
            if (got !== post[i])
                $display("[TB] FAIL post_reset cycle %0d: got %b want %b (a_out,valid,busy,done)", i, got, post[i]);
            else
                passed++;
        end
    endtask

    initial begin
        total       = 0;
        passed      = 0;
        rst         = 1'b0;
        bus.start   = 1'b0;
        bus.pattern = '0;
        bus.len     = '0;
        bus.reps    = '0;
        test_reset();
        test_single(4'd1);
        test_repeat();
        test_single(4'd0);
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
